// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: freezes each core, sets its id, loads CCE
// microcode, sets CCE mode, then unfreezes every core over a credit-based cfg link.
module bp_cfg_loader #(
    parameter int num_core_p              = 1,
    parameter int cfg_core_width_p        = 8,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 32,
    parameter int num_cce_instr_ram_els_p = 256,
    parameter int cce_instr_width_p       = 64,
    parameter int max_credits_p           = 4,
    localparam int uaw_lp = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1,
    localparam int crw_lp = $clog2(max_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    output logic [uaw_lp-1:0]            ucode_addr_o,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         cfg_v_o,
    output logic [cfg_core_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         credit_i,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam logic [cfg_core_width_p-1:0] last_core_lp   = cfg_core_width_p'(num_core_p - 1);
    localparam logic [uaw_lp-1:0]           last_uc_lp     = uaw_lp'(num_cce_instr_ram_els_p - 1);
    localparam logic [crw_lp-1:0]           credits_max_lp = crw_lp'(max_credits_p);

    localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] addr_mode_lp   = cfg_addr_width_p'(16'h0003);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FREEZE,
        S_CORE_ID,
        S_UCODE_RD,
        S_UCODE_LO,
        S_UCODE_HI,
        S_MODE,
        S_UNFREEZE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                           state;
    logic [cfg_core_width_p-1:0]      core_idx;
    logic [uaw_lp-1:0]                uc_idx;
    logic [crw_lp-1:0]                credits;
    logic                             word_pending;
    logic [cce_instr_width_p-1:0]     word_r;

    logic                             is_write;
    logic                             send;
    logic [cfg_addr_width_p-1:0]      wr_addr;
    logic [cfg_data_width_p-1:0]      wr_data;
    logic [cfg_data_width_p-1:0]      lo_half;

    function automatic logic [cfg_addr_width_p-1:0] ucode_cfg_addr(
        input logic [uaw_lp-1:0] idx,
        input logic              hi
    );
        return cfg_addr_width_p'(32'h8000) + cfg_addr_width_p'({idx, hi});
    endfunction

    function automatic logic [crw_lp-1:0] next_credits(
        input logic [crw_lp-1:0] cur,
        input logic              snd,
        input logic              ret
    );
        logic [crw_lp-1:0] nxt;
        nxt = cur;
        if (snd && !ret)
            nxt = cur - 1'b1;
        else if (ret && !snd && (cur != credits_max_lp))
            nxt = cur + 1'b1;
        return nxt;
    endfunction

    assign is_write = state inside {S_FREEZE, S_CORE_ID, S_UCODE_LO, S_UCODE_HI, S_MODE, S_UNFREEZE};
    assign send     = is_write && (credits != '0);

    // The ROM word arrives during the first UCODE_LO cycle; later (stalled) cycles use the latched copy.
    assign lo_half = word_pending ? ucode_data_i[cfg_data_width_p-1:0] : word_r[cfg_data_width_p-1:0];

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_FREEZE: begin
                wr_addr = addr_freeze_lp;
                wr_data = cfg_data_width_p'(1);
            end
            S_CORE_ID: begin
                wr_addr = addr_core_id_lp;
                wr_data = cfg_data_width_p'(core_idx);
            end
            S_UCODE_LO: begin
                wr_addr = ucode_cfg_addr(uc_idx, 1'b0);
                wr_data = lo_half;
            end
            S_UCODE_HI: begin
                wr_addr = ucode_cfg_addr(uc_idx, 1'b1);
                wr_data = word_r[2*cfg_data_width_p-1:cfg_data_width_p];
            end
            S_MODE: begin
                wr_addr = addr_mode_lp;
                wr_data = cfg_data_width_p'(1);
            end
            S_UNFREEZE: begin
                wr_addr = addr_freeze_lp;
                wr_data = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if ((state == S_UCODE_LO) && word_pending)
            word_r <= ucode_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            credits <= credits_max_lp;
        else
            credits <= next_credits(credits, send, credit_i);
    end

    credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(credit_i && !send && (credits == credits_max_lp)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= S_IDLE;
            core_idx     <= '0;
            uc_idx       <= '0;
            word_pending <= 1'b0;
            ucode_addr_o <= '0;
            cfg_v_o      <= 1'b0;
            cfg_core_o   <= '0;
            cfg_addr_o   <= '0;
            cfg_data_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            cfg_v_o <= send;
            if (send) begin
                cfg_core_o <= core_idx;
                cfg_addr_o <= wr_addr;
                cfg_data_o <= wr_data;
            end
            if ((state == S_UCODE_LO) && word_pending)
                word_pending <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state    <= S_FREEZE;
                        core_idx <= '0;
                        uc_idx   <= '0;
                        busy_o   <= 1'b1;
                        done_o   <= 1'b0;
                    end
                end
                S_FREEZE: begin
                    if (send)
                        state <= S_CORE_ID;
                end
                S_CORE_ID: begin
                    if (send) begin
                        state        <= S_UCODE_RD;
                        ucode_addr_o <= uc_idx;
                    end
                end
                S_UCODE_RD: begin
                    state        <= S_UCODE_LO;
                    word_pending <= 1'b1;
                end
                S_UCODE_LO: begin
                    if (send)
                        state <= S_UCODE_HI;
                end
                S_UCODE_HI: begin
                    if (send) begin
                        if (uc_idx == last_uc_lp) begin
                            uc_idx <= '0;
                            state  <= S_MODE;
                        end else begin
                            uc_idx       <= uc_idx + 1'b1;
                            ucode_addr_o <= uc_idx + 1'b1;
                            state        <= S_UCODE_RD;
                        end
                    end
                end
                S_MODE: begin
                    if (send) begin
                        if (core_idx == last_core_lp) begin
                            core_idx <= '0;
                            state    <= S_UNFREEZE;
                        end else begin
                            core_idx <= core_idx + 1'b1;
                            state    <= S_FREEZE;
                        end
                    end
                end
                S_UNFREEZE: begin
                    if (send) begin
                        if (core_idx == last_core_lp) begin
                            core_idx <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            core_idx <= core_idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Completion is only reported once every issued write has been retired.
                    if (credits == credits_max_lp) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: registered ROM model, randomized credit returner and
// an expected-write list built directly from the boot sequence rules.
module tb_bp_cfg_loader;

    localparam int NC   = 2;
    localparam int ELS  = 4;
    localparam int CRED = 4;
    localparam int N_WR = NC * (3 + 2 * ELS) + NC;

    typedef struct packed {
        logic [7:0]  core;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  ucode_addr_o;
    logic [63:0] ucode_data_i = '0;
    logic        cfg_v_o;
    logic [7:0]  cfg_core_o;
    logic [15:0] cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic        credit_i;
    logic        busy_o;
    logic        done_o;

    logic        cr_auto = 1'b0;
    logic        cr_man = 1'b0;
    logic        auto_cr = 1'b0;
    int unsigned dmin = 2, dmax = 2;
    int unsigned cyc = 0, last_due = 0;
    int unsigned due_q[$];
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [63:0] rom_mem [0:ELS-1];
    int          n_tests = 0, n_fail = 0;

    assign credit_i = cr_auto | cr_man;

    bp_cfg_loader #(
        .num_core_p(NC), .cfg_core_width_p(8), .cfg_addr_width_p(16), .cfg_data_width_p(32),
        .num_cce_instr_ram_els_p(ELS), .cce_instr_width_p(64), .max_credits_p(CRED)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
        .ucode_addr_o(ucode_addr_o), .ucode_data_i(ucode_data_i),
        .cfg_v_o(cfg_v_o), .cfg_core_o(cfg_core_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .credit_i(credit_i), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) ucode_data_i <= rom_mem[ucode_addr_o];

    function automatic wr_t mk(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d);
        wr_t w;
        w.core = c; w.addr = a; w.data = d;
        return w;
    endfunction

    // Monitor plus credit returner: each observed write is retired once, after a random delay.
    always @(negedge clk_i) begin
        int unsigned d;
        cyc++;
        if (!reset_n_i) begin
            due_q.delete();
            last_due = 0;
            cr_auto = 1'b0;
        end else begin
            if (cfg_v_o === 1'b1) begin
                obs_q.push_back(mk(cfg_core_o, cfg_addr_o, cfg_data_o));
                if (auto_cr) begin
                    d = cyc + $urandom_range(dmax, dmin);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    due_q.push_back(d);
                end
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                cr_auto = 1'b1;
                void'(due_q.pop_front());
            end else begin
                cr_auto = 1'b0;
            end
        end
    end

    task automatic build_exp();
        exp_q.delete();
        for (int c = 0; c < NC; c++) begin
            exp_q.push_back(mk(8'(c), 16'h0001, 32'd1));
            exp_q.push_back(mk(8'(c), 16'h0002, 32'(c)));
            for (int i = 0; i < ELS; i++) begin
                exp_q.push_back(mk(8'(c), 16'(32'h8000 + 2 * i), rom_mem[i][31:0]));
                exp_q.push_back(mk(8'(c), 16'(32'h8000 + 2 * i + 1), rom_mem[i][63:32]));
            end
            exp_q.push_back(mk(8'(c), 16'h0003, 32'd1));
        end
        for (int c = 0; c < NC; c++) exp_q.push_back(mk(8'(c), 16'h0001, 32'd0));
    endtask

    task automatic fixed_rom();
        for (int i = 0; i < ELS; i++) rom_mem[i] = {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)};
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0; start_i = 1'b0; cr_man = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i); #1;
        obs_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
    endtask

    task automatic test_reset();
        fixed_rom();
        @(posedge clk_i); #1;
        n_tests++;
        if ({cfg_v_o, busy_o, done_o, ucode_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: v=%b busy=%b done=%b ua=%h core=%h addr=%h data=%h, all must be 0",
                     cfg_v_o, busy_o, done_o, ucode_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o);
        end
        @(negedge clk_i); reset_n_i = 1'b1;
        repeat (8) @(negedge clk_i);
        #1;
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b done=%b writes=%0d, required 0/0/0", busy_o, done_o, obs_q.size());
        end
    endtask

    task automatic test_full_sequence();
        int w;
        fixed_rom(); build_exp();
        auto_cr = 1'b1; dmin = 2; dmax = 2;
        do_reset();
        pulse_start();
        #1;
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", busy_o); end
        w = 0;
        while (done_o !== 1'b1 && w < 500) begin @(negedge clk_i); w++; end
        #1;
        n_tests++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL full_done: done=%b busy=%b want 1/0", done_o, busy_o);
        end
        n_tests++;
        if (obs_q.size() != N_WR) begin
            n_fail++; $display("FAIL full_count: got %0d writes want %0d", obs_q.size(), N_WR);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL full_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
        repeat (10) @(negedge clk_i);
        #1;
        n_tests++;
        if (done_o !== 1'b1 || obs_q.size() != N_WR) begin
            n_fail++; $display("FAIL done_sticky: done=%b writes=%0d want 1/%0d", done_o, obs_q.size(), N_WR);
        end
    endtask

    task automatic test_random();
        int w;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < ELS; i++) rom_mem[i] = {$urandom, $urandom};
            build_exp();
            auto_cr = 1'b1; dmin = 1; dmax = $urandom_range(7, 2);
            do_reset();
            repeat ($urandom_range(4, 0)) @(negedge clk_i);
            pulse_start();
            w = 0;
            while (done_o !== 1'b1 && w < 800) begin @(negedge clk_i); w++; end
            #1;
            n_tests++;
            if (done_o !== 1'b1 || obs_q.size() != N_WR) begin
                n_fail++; $display("FAIL rand%0d_done: done=%b writes=%0d want 1/%0d", it, done_o, obs_q.size(), N_WR);
            end
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
                n_tests++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h/%h/%h want %h/%h/%h", it, k, obs_q[k].core, obs_q[k].addr,
                             obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
                end
            end
        end
    endtask

    task automatic test_credit_stall();
        fixed_rom(); build_exp();
        auto_cr = 1'b0;
        do_reset();
        pulse_start();
        repeat (40) @(negedge clk_i);
        #1;
        n_tests++;
        if (obs_q.size() != CRED || cfg_v_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_count: writes=%0d v=%b busy=%b want %0d/0/1", obs_q.size(), cfg_v_o, busy_o, CRED);
        end
        cr_man = 1'b1;
        @(negedge clk_i); #1;
        cr_man = 1'b0;
        repeat (30) @(negedge clk_i);
        #1;
        n_tests++;
        if (obs_q.size() != CRED + 1) begin
            n_fail++; $display("FAIL stall_one_credit: got %0d writes want %0d", obs_q.size(), CRED + 1);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
    endtask

    task automatic test_credit_coincident();
        int w;
        fixed_rom(); build_exp();
        auto_cr = 1'b0;
        do_reset();
        pulse_start();
        w = 0;
        while (obs_q.size() < 3 && w < 50) begin @(negedge clk_i); #1; w++; end
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL coin_reach3: got %0d writes want 3", obs_q.size());
        end
        // The last credit is being spent this cycle; return one at the same edge.
        cr_man = 1'b1;
        @(negedge clk_i); #1;
        cr_man = 1'b0;
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++; $display("FAIL coin_next: got %0d writes want 4", obs_q.size());
        end
        repeat (30) @(negedge clk_i);
        #1;
        n_tests++;
        if (obs_q.size() != 5) begin
            n_fail++; $display("FAIL coin_total: got %0d writes want 5", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL coin_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        fixed_rom(); build_exp();
        auto_cr = 1'b1; dmin = 2; dmax = 2;
        do_reset();
        pulse_start();
        w = 0;
        while (obs_q.size() < 14 && w < 200) begin @(negedge clk_i); #1; w++; end
        n_tests++;
        if (obs_q.size() != 14) begin
            n_fail++; $display("FAIL mid_reach: got %0d writes want 14", obs_q.size());
        end
        reset_n_i = 1'b0;
        #1;
        n_tests++;
        if ({cfg_v_o, busy_o, done_o, ucode_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: v=%b busy=%b done=%b ua=%h core=%h addr=%h data=%h, all must be 0",
                     cfg_v_o, busy_o, done_o, ucode_addr_o, cfg_core_o, cfg_addr_o, cfg_data_o);
        end
        repeat (5) @(negedge clk_i);
        #1;
        n_tests++;
        if (obs_q.size() != 14) begin
            n_fail++; $display("FAIL mid_no_writes: got %0d writes want 14", obs_q.size());
        end
        reset_n_i = 1'b1;
        @(negedge clk_i); #1;
        obs_q.delete();
        pulse_start();
        w = 0;
        while (done_o !== 1'b1 && w < 500) begin @(negedge clk_i); w++; end
        #1;
        n_tests++;
        if (done_o !== 1'b1 || obs_q.size() != N_WR) begin
            n_fail++; $display("FAIL mid_replay: done=%b writes=%0d want 1/%0d", done_o, obs_q.size(), N_WR);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL mid_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
    endtask

    task automatic test_start_busy_and_restart();
        int w;
        fixed_rom(); build_exp();
        auto_cr = 1'b1; dmin = 2; dmax = 3;
        do_reset();
        pulse_start();
        repeat (5) @(negedge clk_i);
        pulse_start();
        repeat (10) @(negedge clk_i);
        pulse_start();
        w = 0;
        while (done_o !== 1'b1 && w < 500) begin @(negedge clk_i); w++; end
        #1;
        n_tests++;
        if (done_o !== 1'b1 || obs_q.size() != N_WR) begin
            n_fail++; $display("FAIL busy_start: done=%b writes=%0d want 1/%0d", done_o, obs_q.size(), N_WR);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL busy_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
        obs_q.delete();
        @(negedge clk_i); start_i = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL restart_flags: done=%b busy=%b want 0/1", done_o, busy_o);
        end
        @(negedge clk_i); start_i = 1'b0;
        w = 0;
        while (done_o !== 1'b1 && w < 500) begin @(negedge clk_i); w++; end
        #1;
        n_tests++;
        if (done_o !== 1'b1 || obs_q.size() != N_WR) begin
            n_fail++; $display("FAIL restart_done: done=%b writes=%0d want 1/%0d", done_o, obs_q.size(), N_WR);
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_tests++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL restart_beat%0d: got %h/%h/%h want %h/%h/%h", k, obs_q[k].core, obs_q[k].addr,
                         obs_q[k].data, exp_q[k].core, exp_q[k].addr, exp_q[k].data);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_sequence();
        test_random();
        test_credit_stall();
        test_credit_coincident();
        test_reset_mid();
        test_start_busy_and_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Boot-time configuration sequencer that consumes a processor configuration (core count, CCE microcode depth, cfg bus widths, credit count).
- Emits the ordered stream of cfg-bus writes that freezes each core, assigns its core id, loads CCE microcode, sets CCE mode, then unfreezes all cores.
- Sits between the host/testbench boot path and the per-tile cfg link. Flow control is credit-based.

Parameters:
- num_core_p, 1, number of cores to configure (1..2^cfg_core_width_p).
- cfg_core_width_p, 8, width of cfg core-select field.
- cfg_addr_width_p, 16, width of cfg address.
- cfg_data_width_p, 32, width of cfg data.
- num_cce_instr_ram_els_p, 256, microcode entries per CCE.
- cce_instr_width_p, 64, microcode word width; fixed at 2*cfg_data_width_p.
- max_credits_p, 4, outstanding cfg writes allowed.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; begins the sequence from IDLE.
- ucode_addr_o  out  log2(num_cce_instr_ram_els_p)  microcode ROM read address.
- ucode_data_i  in  cce_instr_width_p  ROM data, valid exactly 1 cycle after ucode_addr_o.
- cfg_v_o  out  1  cfg write valid. One beat per cycle; consumes one credit.
- cfg_core_o  out  cfg_core_width_p  target core.
- cfg_addr_o  out  cfg_addr_width_p  target register.
- cfg_data_o  out  cfg_data_width_p  write data.
- credit_i  in  1  one write retired downstream.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sequence complete and all credits returned; sticky until next start_i.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, credits=max_credits_p. All outputs 0, including cfg_v_o, busy_o, done_o and ucode_addr_o.
- Address map:
  - 0x0001 freeze (data 1 = freeze, 0 = run).
  - 0x0002 core_id.
  - 0x0003 cce_mode (1 = normal).
  - 0x8000+2*i low half of microcode word i; 0x8000+2*i+1 high half.
- States and sequence:
  - IDLE -> FREEZE on start_i.
  - Per core c (0..num_core_p-1): FREEZE(data 1) -> CORE_ID(data c) -> [UCODE_RD -> UCODE_LO -> UCODE_HI] for i=0..els-1 -> MODE(data 1).
  - After the last core: UNFREEZE(data 0) for each core 0..num_core_p-1 -> DRAIN -> DONE.
- UCODE_RD: drives ucode_addr_o=i, no cfg write. Next cycle ucode_data_i is latched into a word register. UCODE_LO sends word[31:0]; UCODE_HI sends word[63:32].
- Each write state holds with cfg_v_o=0 while credits==0. When credits>0 it asserts cfg_v_o for exactly one cycle and advances. There is no back-to-back stall beyond credits.
- Credit counter (width log2(max_credits_p+1)):
  - send & !credit_i: decrement.
  - credit_i & !send: increment.
  - both in the same cycle: unchanged.
  - credit_i at credits==max_credits_p: saturates, and a simulation assertion fires.
- DRAIN waits for credits==max_credits_p, then enters DONE: done_o=1, busy_o=0.
- busy_o=1 in every state except IDLE and DONE.
- start_i: ignored while busy. In DONE it restarts the sequence (done_o clears the same cycle the FREEZE state is entered).
- Counters: core index and ucode index wrap to 0 after their last value. Index i rolls over after num_cce_instr_ram_els_p-1 and moves to MODE.
- Reset asserted mid-sequence: immediate return to the reset state, and no further cfg_v_o. Credits in flight are forgotten (downstream is reset together).
- Total writes = num_core_p*(3 + 2*num_cce_instr_ram_els_p) + num_core_p.

Test Plan:
- num_core_p=2, els=4, max_credits_p=4, credit_i returned 2 cycles after each write, start_i pulse -> exactly 24 cfg writes in order. Core 0 then core 1: freeze, id, 8 ucode halves (addrs 0x8000..0x8007), mode. Then unfreeze core 0 and core 1. Then done_o=1.
- ROM word i = {32'hA000_0000+i, 32'h5000_0000+i} -> write to addr 0x8000+2i carries 0x5000_000i; write to addr 0x8000+2i+1 carries 0xA000_000i.
- credit_i held 0 after start -> exactly 4 writes issued, then cfg_v_o=0 indefinitely. A single credit_i pulse -> exactly one more write.
- credit_i coincident with a send at credits==1 -> credits stays 1 and the next write issues the following cycle.
- reset_n_i low during the UCODE_HI of core 1 -> outputs 0 immediately. After release, start_i replays the full 24-write sequence from core 0 freeze.
- start_i pulsed while busy -> no effect on sequence or write count. start_i pulsed in DONE -> done_o drops and the sequence restarts.
